// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Round-robin arbiter in front of a single saturating unsigned adder.
//   N requesters each present an operand pair (x, y); one is granted, its
//   operands are captured, the sum is computed one cycle later and held as a
//   response until the consumer accepts it.  One operation is in flight at a
//   time, so throughput is at most one operation every three cycles.
//
//   Handshakes (both sides): a transfer happens in a cycle where valid and
//   ready are both high at the rising edge of clk_i.  On the request side
//   req_ready_o is a combinational one-hot grant that exists only in IDLE.
//   On the response side rsp_valid_o is high only in RESP, and the payload
//   (rsp_id_o, sum_o, of_o) stays stable until rsp_ready_i is seen high.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   req_valid_i  : [N]    per-requester request
//   req_ready_o  : [N]    one-hot grant/accept
//   x_i, y_i     : [N*W]  requester k operands in bits [k*W +: W]
//   rsp_valid_o  : result available
//   rsp_ready_i  : consumer accepts result
//   rsp_id_o     : [clog2(N)] owner of the result
//   sum_o        : [W]    saturated sum
//   of_o         : overflow (carry out) flag for sum_o
//   dbg_state_o  : [2]    current FSM state, for observation only
// -----------------------------------------------------------------------------
module adder_arbiter #(
   parameter int W = 8,
   parameter int N = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [N-1:0]           req_valid_i,
   output logic [N-1:0]           req_ready_o,
   input  logic [N*W-1:0]         x_i,
   input  logic [N*W-1:0]         y_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [$clog2(N)-1:0]   rsp_id_o,
   output logic [W-1:0]           sum_o,
   output logic                   of_o,
   output logic [1:0]             dbg_state_o
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [IW-1:0]   r_ptr;       // highest-priority requester for next grant
   logic [IW-1:0]   r_gid;       // id captured at accept
   logic [W-1:0]    r_x;
   logic [W-1:0]    r_y;
   logic [IW-1:0]   r_rsp_id;    // id published with the response
   logic [W-1:0]    r_sum;
   logic            r_of;

   logic            w_any;
   logic [IW-1:0]   w_gnt;
   logic [N-1:0]    w_req_ready;
   logic            w_accept;
   logic            w_rsp_hs;
   logic [W:0]      w_sum;

   // Round-robin pick: scan offsets from the highest down so that the
   // smallest offset from r_ptr with a pending request is written last.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_valid_i[(int'(r_ptr) + i) % N]) begin
            w_any = 1'b1;
            w_gnt = IW'((int'(r_ptr) + i) % N);
         end
      end
   end

   // Next state and handshake decode.
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      w_accept    = 1'b0;
      w_rsp_hs    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               // The grant only goes to a requester whose valid is high,
               // so a raised grant is always an accept.
               w_req_ready[w_gnt] = 1'b1;
               w_accept           = 1'b1;
               w_state_nxt        = ST_CALC;
            end
         end
         ST_CALC: begin
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               w_rsp_hs    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_sum = {1'b0, r_x} + {1'b0, r_y};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr    <= '0;
         r_gid    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_rsp_id <= '0;
         r_sum    <= '0;
         r_of     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_x   <= x_i[w_gnt*W +: W];
            r_y   <= y_i[w_gnt*W +: W];
            r_gid <= w_gnt;
         end
         // Result registers (including the id) update only here, so the
         // previous response stays visible through IDLE and CALC.
         if (r_state == ST_CALC) begin
            r_rsp_id <= r_gid;
            if (w_sum[W]) begin
               r_sum <= '1;
               r_of  <= 1'b1;
            end else begin
               r_sum <= w_sum[W-1:0];
               r_of  <= 1'b0;
            end
         end
         if (w_rsp_hs) begin
            r_ptr <= (r_rsp_id == IW'(N - 1)) ? '0 : r_rsp_id + 1'b1;
         end
      end
   end

   assign req_ready_o = w_req_ready;
   assign rsp_valid_o = (r_state == ST_RESP);
   assign rsp_id_o    = r_rsp_id;
   assign sum_o       = r_sum;
   assign of_o        = r_of;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//   Directed bench for adder_arbiter with W=8, N=4.  Inputs change 1 ns after
//   a rising edge; outputs are checked 1 ns after that, well away from edges.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk_i;
   logic           rst_ni;
   logic [N-1:0]   req_valid_i;
   logic [N-1:0]   req_ready_o;
   logic [N*W-1:0] x_i;
   logic [N*W-1:0] y_i;
   logic           rsp_valid_o;
   logic           rsp_ready_i;
   logic [1:0]     rsp_id_o;
   logic [W-1:0]   sum_o;
   logic           of_o;
   logic [1:0]     dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;

   adder_arbiter #(.W(W), .N(N)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .x_i         (x_i),
      .y_i         (y_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_id_o    (rsp_id_o),
      .sum_o       (sum_o),
      .of_o        (of_o),
      .dbg_state_o (dbg_state_o)
   );

   // clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // One isolated operation from requester k; FSM must be in IDLE on entry
   // and k must be the only requester.  Returns in IDLE after the handshake.
   task automatic single_op(input int k, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] esum, input logic eof);
      x_i = 32'hA5C3_5A3C;   // other lanes carry junk that must be ignored
      y_i = 32'h7E81_E718;
      x_i[k*W +: W] = x;
      y_i[k*W +: W] = y;
      req_valid_i = 4'(1 << k);
      #1;
      check("op_grant", req_ready_o, 32'(1 << k));
      step();                         // accept edge -> CALC
      req_valid_i = '0;
      #1;
      check("op_calc_valid", rsp_valid_o, 0);
      check("op_calc_ready", req_ready_o, 0);
      step();                         // -> RESP
      #1;
      check("op_rsp_valid", rsp_valid_o, 1);
      check("op_rsp_id", rsp_id_o, k);
      check("op_sum", sum_o, esum);
      check("op_of", of_o, eof);
      rsp_ready_i = 1'b1;
      step();                         // handshake -> IDLE
      rsp_ready_i = 1'b0;
      #1;
      check("op_idle_valid", rsp_valid_o, 0);
      check("op_hold_sum", sum_o, esum);
   endtask

   initial begin
      rst_ni      = 1'b0;
      req_valid_i = '0;
      x_i         = '0;
      y_i         = '0;
      rsp_ready_i = 1'b0;
      #3;
      check("rst_valid", rsp_valid_o, 0);
      check("rst_sum", sum_o, 0);
      check("rst_of", of_o, 0);
      check("rst_id", rsp_id_o, 0);
      check("rst_ready", req_ready_o, 0);
      step();
      rst_ni = 1'b1;

      // single request and saturation boundaries; ptr walks 3,2,1,0
      single_op(2, 8'h10, 8'h20, 8'h30, 1'b0);
      single_op(1, 8'hFF, 8'h01, 8'hFF, 1'b1);
      single_op(0, 8'hFE, 8'h01, 8'hFF, 1'b0);
      single_op(3, 8'h80, 8'h80, 8'hFF, 1'b1);

      // pointer wrap: after requester 3, ptr = 0 so 0 beats 3
      x_i = '0; y_i = '0;
      x_i[0*W +: W] = 8'h05; y_i[0*W +: W] = 8'h06;
      x_i[3*W +: W] = 8'h77; y_i[3*W +: W] = 8'h77;
      req_valid_i = 4'b1001;
      #1;
      check("wrap_grant", req_ready_o, 32'b0001);
      step();
      req_valid_i = '0;
      step();
      #1;
      check("wrap_id", rsp_id_o, 0);
      check("wrap_sum", sum_o, 8'h0B);
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;             // ptr = 1

      // backpressure: requester 2 alone, then stall 5 cycles in RESP
      x_i[2*W +: W] = 8'h40; y_i[2*W +: W] = 8'h41;
      req_valid_i = 4'b0100;
      #1;
      check("bp_grant", req_ready_o, 32'b0100);
      step();
      req_valid_i = '0;
      step();                         // now RESP
      req_valid_i = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_valid", rsp_valid_o, 1);
         check("bp_id", rsp_id_o, 2);
         check("bp_sum", sum_o, 8'h81);
         check("bp_of", of_o, 0);
         check("bp_ready", req_ready_o, 0);
         step();
      end
      rsp_ready_i = 1'b1;
      step();                         // handshake -> IDLE, ptr = 3
      rsp_ready_i = 1'b0;
      #1;
      check("bp_rel_valid", rsp_valid_o, 0);
      check("bp_rel_grant", req_ready_o, 32'b1000);
      // everyone withdraws before the grant edge: nothing happens
      req_valid_i = '0;
      #1;
      check("wd_ready", req_ready_o, 0);
      step();
      #1;
      check("wd_valid", rsp_valid_o, 0);
      check("wd_sum_held", sum_o, 8'h81);
      // stray rsp_ready in IDLE has no effect
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      #1;
      check("stray_valid", rsp_valid_o, 0);

      // reset during CALC: ptr is 3, requester 1 is the only one
      x_i[1*W +: W] = 8'h11; y_i[1*W +: W] = 8'h22;
      req_valid_i = 4'b0010;
      #1;
      check("mid_grant", req_ready_o, 32'b0010);
      step();                         // CALC
      req_valid_i = '0;
      rst_ni = 1'b0;
      #1;
      check("mid_rst_valid", rsp_valid_o, 0);
      check("mid_rst_sum", sum_o, 0);
      check("mid_rst_id", rsp_id_o, 0);
      check("mid_rst_of", of_o, 0);
      step();
      rst_ni = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         check("post_rst_valid", rsp_valid_o, 0);
         step();
      end

      // fairness: all requesting, consumer always ready; ptr back to 0
      for (int k = 0; k < N; k++) begin
         x_i[k*W +: W] = 8'(8'h10 * k + 1);
         y_i[k*W +: W] = 8'h03;
      end
      req_valid_i = 4'b1111;
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         int g;
         g = i % N;
         #1;
         check("rr_grant", req_ready_o, 32'(1 << g));
         check("rr_idle_valid", rsp_valid_o, 0);
         step();
         #1;
         check("rr_calc_valid", rsp_valid_o, 0);
         step();
         #1;
         check("rr_rsp_valid", rsp_valid_o, 1);
         check("rr_id", rsp_id_o, g);
         check("rr_sum", sum_o, 32'(8'h10 * g + 4));
         step();
      end
      req_valid_i = '0;
      rsp_ready_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
